// File: rtl/calc_pkg.sv
// calc_pkg -- definitions shared by the calculator block.
//   op_e          : latched operation encoding (ADD=0, SUB=1, MUL=2, DIV=3)
//   CALC_MAX_VAL  : default upper limit of each operand
//   DIG_*/SEG_*   : 4-bit digit codes and active-low segment patterns
//                   ({dp,g,f,e,d,c,b,a}) for 0-9, blank and minus
//   seg_decode()  : digit code -> segment pattern
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam int unsigned CALC_MAX_VAL = 99;

  // Digit codes 0-9 are the decimal value itself.
  localparam logic [3:0] DIG_BLANK = 4'd10;
  localparam logic [3:0] DIG_MINUS = 4'd11;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      DIG_MINUS: seg = SEG_MINUS;
      default:   seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/calc_ssg_mux.sv
// calc_ssg_mux -- 4-digit seven-segment multiplexer and decoder.
//   i_dig0..i_dig3 : digit codes (digit 3 leftmost), see calc_pkg
//   i_refresh      : free-running refresh counter; top 2 bits pick the digit
//   o_anode        : digit enables, active-low, one-hot-low
//   o_ssg          : segments {dp,g,f,e,d,c,b,a}, active-low, dp always off
module calc_ssg_mux
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic [3:0]              i_dig0,
  input  logic [3:0]              i_dig1,
  input  logic [3:0]              i_dig2,
  input  logic [3:0]              i_dig3,
  input  logic [REFRESH_BITS-1:0] i_refresh,
  output logic [3:0]              o_anode,
  output logic [7:0]              o_ssg
);

  logic [1:0] w_sel;
  logic [3:0] w_code;
  logic       w_unused;

  assign w_sel    = i_refresh[REFRESH_BITS-1 -: 2];
  // Low counter bits only set the slot length.
  assign w_unused = ^i_refresh[REFRESH_BITS-3:0];

  always_comb begin
    o_anode = 4'b1110;
    w_code  = i_dig0;
    case (w_sel)
      2'd0: begin o_anode = 4'b1110; w_code = i_dig0; end
      2'd1: begin o_anode = 4'b1101; w_code = i_dig1; end
      2'd2: begin o_anode = 4'b1011; w_code = i_dig2; end
      2'd3: begin o_anode = 4'b0111; w_code = i_dig3; end
      default: begin o_anode = 4'b1110; w_code = i_dig0; end
    endcase
  end

  assign o_ssg = seg_decode(w_code);

endmodule

// File: rtl/calculator.sv
// calculator -- two-operand push-button calculator with 4-digit display.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   B[0]     : display mode (0 operands, 1 result)
//   B[4:1]   : add, sub, mul, div select (edge-triggered)
//   B[8:5]   : n2 down, n2 up, n1 down, n1 up (edge-triggered)
//   ssgAnode : digit enables, active-low
//   ssg      : segments {dp,g,f,e,d,c,b,a}, active-low
//   result   : registered result magnitude
//   n1, n2   : current operands (0..MAX_VAL)
// Build option: define CALC_WRAP_EN to make operands wrap instead of saturate.
module calculator
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17,
  parameter int unsigned MAX_VAL      = CALC_MAX_VAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  B,
  output logic [3:0]  ssgAnode,
  output logic [7:0]  ssg,
  output logic [13:0] result,
  output logic [6:0]  n1,
  output logic [6:0]  n2
);

`ifdef CALC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [6:0] L_MAX = 7'(MAX_VAL);

  logic [7:0]              r_b_prev;
  logic                    r_armed;
  logic [6:0]              r_n1;
  logic [6:0]              r_n2;
  op_e                     r_op;
  logic [13:0]             r_result;
  logic                    r_neg;
  logic                    r_err;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic                    r_mode;

  logic [7:0] w_edge;
  logic       w_slot_start;
  logic       w_mode;
  logic [3:0] w_d0, w_d1, w_d2, w_d3;
  logic [3:0] w_th, w_hu, w_te, w_un;

  // r_armed stays low for the first cycle after reset so r_b_prev captures
  // any button still held, instead of that button registering as an edge.
  assign w_edge = r_armed ? (B[8:1] & ~r_b_prev) : '0;

  function automatic logic [6:0] step(input logic [6:0] v, input logic up,
                                      input logic dn);
    logic [6:0] nv;
    nv = v;
    if (up && !dn) begin
      if (v == L_MAX) nv = WRAP ? '0 : L_MAX;
      else            nv = v + 7'd1;
    end else if (dn && !up) begin
      if (v == '0) nv = WRAP ? L_MAX : '0;
      else         nv = v - 7'd1;
    end
    return nv;
  endfunction

  assign w_slot_start = (r_refresh[REFRESH_BITS-3:0] == '0);
  // Mode is sampled on the first cycle of each digit slot and held for the
  // rest of it, so a B[0] change lands on a slot boundary.
  assign w_mode = w_slot_start ? B[0] : r_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_b_prev  <= '0;
      r_armed   <= 1'b0;
      r_n1      <= '0;
      r_n2      <= '0;
      r_op      <= OP_ADD;
      r_result  <= '0;
      r_neg     <= 1'b0;
      r_err     <= 1'b0;
      r_refresh <= '0;
      r_mode    <= 1'b0;
    end else begin
      r_b_prev  <= B[8:1];
      r_armed   <= 1'b1;
      r_n1      <= step(r_n1, w_edge[4], w_edge[5]);
      r_n2      <= step(r_n2, w_edge[6], w_edge[7]);
      r_refresh <= r_refresh + REFRESH_BITS'(1);
      if (w_slot_start) r_mode <= B[0];

      if      (w_edge[0]) r_op <= OP_DIV;
      else if (w_edge[1]) r_op <= OP_MUL;
      else if (w_edge[2]) r_op <= OP_SUB;
      else if (w_edge[3]) r_op <= OP_ADD;

      case (r_op)
        OP_ADD: r_result <= 14'(r_n1) + 14'(r_n2);
        OP_SUB: r_result <= (r_n1 >= r_n2) ? 14'(r_n1 - r_n2)
                                           : 14'(r_n2 - r_n1);
        OP_MUL: r_result <= 14'(r_n1) * 14'(r_n2);
        OP_DIV: r_result <= (r_n2 == '0) ? '0 : 14'(r_n1 / r_n2);
        default: r_result <= '0;
      endcase
      r_neg <= (r_op == OP_SUB) && (r_n1 < r_n2);
      r_err <= (r_op == OP_DIV) && (r_n2 == '0);
    end
  end

  assign w_th = 4'((r_result / 14'd1000) % 14'd10);
  assign w_hu = 4'((r_result / 14'd100) % 14'd10);
  assign w_te = 4'((r_result / 14'd10) % 14'd10);
  assign w_un = 4'(r_result % 14'd10);

  always_comb begin
    w_d0 = '0;
    w_d1 = '0;
    w_d2 = '0;
    w_d3 = '0;
    if (!w_mode) begin
      w_d3 = 4'(r_n1 / 7'd10);
      w_d2 = 4'(r_n1 % 7'd10);
      w_d1 = 4'(r_n2 / 7'd10);
      w_d0 = 4'(r_n2 % 7'd10);
    end else if (r_err) begin
      w_d3 = DIG_MINUS;
      w_d2 = DIG_MINUS;
      w_d1 = DIG_MINUS;
      w_d0 = DIG_MINUS;
    end else begin
      w_d0 = w_un;
      w_d1 = ((w_th | w_hu | w_te) == '0) ? DIG_BLANK : w_te;
      w_d2 = ((w_th | w_hu) == '0) ? DIG_BLANK : w_hu;
      w_d3 = (w_th == '0) ? DIG_BLANK : w_th;
      if (r_neg) w_d3 = DIG_MINUS;
    end
  end

  calc_ssg_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_mux (
    .i_dig0   (w_d0),
    .i_dig1   (w_d1),
    .i_dig2   (w_d2),
    .i_dig3   (w_d3),
    .i_refresh(r_refresh),
    .o_anode  (ssgAnode),
    .o_ssg    (ssg)
  );

  assign result = r_result;
  assign n1     = r_n1;
  assign n2     = r_n2;

endmodule

// File: tb/tb_calculator.sv
// tb_calculator -- self-checking bench for calculator (short refresh counter).
module tb_calculator;

`ifdef CALC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int MAXV = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  B;
  logic [3:0]  ssgAnode;
  logic [7:0]  ssg;
  logic [13:0] result;
  logic [6:0]  n1;
  logic [6:0]  n2;

  calculator #(
    .REFRESH_BITS(4),
    .MAX_VAL     (99)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .B       (B),
    .ssgAnode(ssgAnode),
    .ssg     (ssg),
    .result  (result),
    .n1      (n1),
    .n2      (n2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: operands, op (0 add,1 sub,2 mul,3 div)
  int m_n1, m_n2, m_op;

  typedef struct {
    logic [8:0] b;
    int         reps;
    int         n1;
    int         n2;
    int         res;
    string      disp;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] seg_char(input byte c);
    case (c)
      "0": return 8'hC0;
      "1": return 8'hF9;
      "2": return 8'hA4;
      "3": return 8'hB0;
      "4": return 8'h99;
      "5": return 8'h92;
      "6": return 8'h82;
      "7": return 8'hF8;
      "8": return 8'h80;
      "9": return 8'h90;
      " ": return 8'hFF;
      "-": return 8'hBF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_n1 = 0; m_n2 = 0; m_op = 0;
  endtask

  function automatic int bump(input int v, input bit up, input bit dn);
    if (up && !dn) return WRAP ? (v + 1) % (MAXV + 1) : ((v < MAXV) ? v + 1 : MAXV);
    if (dn && !up) return WRAP ? (v + MAXV) % (MAXV + 1) : ((v > 0) ? v - 1 : 0);
    return v;
  endfunction

  task automatic model_apply(input logic [7:0] e);
    m_n1 = bump(m_n1, e[4], e[5]);
    m_n2 = bump(m_n2, e[6], e[7]);
    if      (e[0]) m_op = 3;
    else if (e[1]) m_op = 2;
    else if (e[2]) m_op = 1;
    else if (e[3]) m_op = 0;
  endtask

  function automatic int model_result();
    case (m_op)
      0: return m_n1 + m_n2;
      1: return (m_n1 > m_n2) ? m_n1 - m_n2 : m_n2 - m_n1;
      2: return m_n1 * m_n2;
      default: return (m_n2 == 0) ? 0 : m_n1 / m_n2;
    endcase
  endfunction

  // Each pulse: press on one negedge, release on the next; one negedge
  // after the last release both operands and result have settled.
  task automatic pulse(input logic [7:0] bits, input int reps);
    for (int i = 0; i < reps; i++) begin
      @(negedge clk); B[8:1] = bits;
      @(negedge clk); B[8:1] = '0;
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_n1"}, int'(n1), m_n1);
    chk({tag, "_n2"}, int'(n2), m_n2);
    chk({tag, "_result"}, int'(result), model_result());
  endtask

  task automatic check_display(input string s, input string tag);
    int idx;
    repeat (8) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk({tag, "_anode_onehot"}, $countones(~ssgAnode), 1);
      idx = 0;
      for (int k = 0; k < 4; k++) if (!ssgAnode[k]) idx = k;
      chk($sformatf("%s_seg_d%0d", tag, idx), int'(ssg), int'(seg_char(s[3-idx])));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{9'b111100000, 10, 0, 0, 0,  "0000"};
    tbl[1]  = '{9'b000100001,  9, 9, 0, 9,  "   9"};
    tbl[2]  = '{9'b000001001,  1, 9, 0, 9,  "   9"};
    tbl[3]  = '{9'b010000000,  3, 9, 3, 6,  "0903"};
    tbl[4]  = '{9'b000000010,  1, 9, 3, 3,  ""};
    tbl[5]  = '{9'b000000101,  1, 9, 3, 27, "  27"};
    tbl[6]  = '{9'b001000000,  9, 0, 3, 0,  ""};
    tbl[7]  = '{9'b010000000,  2, 0, 5, 0,  ""};
    tbl[8]  = '{9'b000001001,  1, 0, 5, 5,  "-  5"};
    tbl[9]  = '{9'b100000001,  5, 0, 0, 0,  "   0"};
    tbl[10] = '{9'b000000011,  1, 0, 0, 0,  "----"};
    tbl[11] = '{9'b010000001,  1, 0, 1, 0,  "   0"};
    tbl[12] = '{9'b000100001,  7, 7, 1, 7,  "   7"};
    tbl[13] = '{9'b000010011,  1, 7, 1, 7,  "   7"};
    tbl[14] = '{9'b000011001,  1, 7, 1, 6,  "   6"};
    tbl[15] = '{9'b000010101,  1, 7, 1, 7,  "   7"};
    tbl[16] = '{9'b011100001,  1, 7, 2, 14, "  14"};

    // Reset state
    B = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_n1", int'(n1), 0);
    chk("rst_n2", int'(n2), 0);
    chk("rst_result", int'(result), 0);
    rst = 1'b1;
    #1;
    chk("rst_anode", int'(ssgAnode), 4'b1110);
    chk("rst_ssg", int'(ssg), 8'hC0);

    // Table-driven scenarios
    for (int i = 0; i < 17; i++) begin
      B[0] = tbl[i].b[0];
      pulse(tbl[i].b[8:1], tbl[i].reps);
      chk($sformatf("tbl%0d_n1", i), int'(n1), tbl[i].n1);
      chk($sformatf("tbl%0d_n2", i), int'(n2), tbl[i].n2);
      chk($sformatf("tbl%0d_result", i), int'(result), tbl[i].res);
      if (tbl[i].disp != "") check_display(tbl[i].disp, $sformatf("tbl%0d", i));
    end
    m_n1 = 7; m_n2 = 2; m_op = 2;

    // Held button counts once
    @(negedge clk); B[8:1] = 8'b0001_0000;
    repeat (6) @(negedge clk);
    B[8:1] = '0;
    @(negedge clk);
    model_apply(8'b0001_0000);
    check_model("held");

    // 4-digit result display: 99*99
    B[0] = 1'b1;
    pulse(8'b0001_0000, 100);
    pulse(8'b0100_0000, 100);
    model_apply(8'b0001_0000);
    m_n1 = WRAP ? 0 : 99;
    m_n2 = WRAP ? 99 : 99;
    if (!WRAP) check_model("big");
    if (!WRAP) check_display("9801", "big");

    // Reset mid-press: held n2-up must not count after release
    @(negedge clk); B[8:1] = 8'b0100_0000;
    @(negedge clk); rst = 1'b0;
    #1;
    model_reset();
    check_model("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    B[8:1] = '0;
    repeat (2) @(negedge clk);
    check_model("held_over_rst");
    pulse(8'b0100_0000, 1);
    model_apply(8'b0100_0000);
    check_model("post_rst_pulse");

    // 100 n1-up pulses: saturate at 99 or wrap to 0
    pulse(8'b0001_0000, 100);
    for (int i = 0; i < 100; i++) model_apply(8'b0001_0000);
    chk("n1_100_pulses", int'(n1), WRAP ? 0 : 99);
    check_model("n1_100");

    // Randomised pulses against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] m;
      m = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      B[0] = 1'($urandom_range(0, 1));
      pulse(m, 1);
      model_apply(m);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculator.md
CALCULATOR -- requirements
Module: calculator

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 17, width of the display-refresh counter; its top 2 bits select the active digit.
REQ-002 SHALL have parameter MAX_VAL, default 99, the upper limit of each operand.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port B, input, 9, button/switch bank:
- [0] display mode
- [1] div, [2] mul, [3] sub, [4] add
- [5] n1 up, [6] n1 down, [7] n2 up, [8] n2 down.
REQ-006 SHALL have port ssgAnode, output, 4, digit enables, active-low, one-hot-low.
REQ-007 SHALL have port ssg, output, 8, segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port result, output, 14, registered result magnitude.
REQ-009 SHALL have ports n1 and n2, output, 7 each, current operands (0..MAX_VAL).

Function
REQ-010 SHALL register B[8:1] each cycle and act only on rising edges (B & ~B_prev); a held button produces one action.
REQ-011 SHALL change operands on edges, regardless of B[0]:
- B[5] edge: n1+1.
- B[6] edge: n1-1.
- B[7] edge: n2+1.
- B[8] edge: n2-1.
REQ-012 SHALL leave an operand unchanged when its up and down edges occur in the same cycle.
REQ-013 SHALL saturate operands: up at MAX_VAL holds MAX_VAL; down at 0 holds 0 (see REQ-025 for the alternative).
REQ-014 SHALL latch a 2-bit op register on any op-button edge.
- Encoding: ADD=0, SUB=1, MUL=2, DIV=3.
- Priority when several edges coincide: DIV > MUL > SUB > ADD.
REQ-015 SHALL recompute result every cycle from the current n1, n2 and op; result SHALL be registered, so it is valid one cycle after an operand or op change.
- ADD: n1+n2.
- SUB: |n1-n2|, with flag neg=1 when n1<n2.
- MUL: n1*n2; maximum 9801, fits 14 bits.
- DIV: floor(n1/n2).
REQ-016 SHALL handle division by zero as follows: result=0 and flag err=1. err SHALL clear when an op other than DIV is selected or when n2 becomes non-zero.
REQ-017 SHALL display operands when B[0]=0.
- Digits 3..0 = n1 tens, n1 units, n2 tens, n2 units.
- Digit 3 is leftmost.
REQ-018 SHALL display the result when B[0]=1.
- Result shown as 4 decimal digits, with leading zeros blanked except digit 0.
- When neg=1, a minus sign (segment g only) SHALL occupy digit 3.
- When err=1, all four digits SHALL show a minus sign.
REQ-019 SHALL keep dp off (1) on all digits.
REQ-020 SHALL advance a free-running REFRESH_BITS counter every cycle and drive exactly one anode low at a time; a change of B[0] takes effect at the next digit slot.

Reset
REQ-021 SHALL, while rst=0, asynchronously force:
- n1=0, n2=0, result=0
- op=ADD, neg=0, err=0
- B_prev=0, refresh counter=0.
REQ-022 SHALL, on reset release, produce ssgAnode=4'b1110 and ssg showing digit 0 of the current mode.
REQ-023 SHALL abandon any pending edge when reset is asserted mid-press; a button still held at release SHALL NOT count, because B_prev is re-captured first.

Configuration
REQ-024 SHALL support macro CALC_WRAP_EN.
REQ-025 SHALL, with CALC_WRAP_EN defined, wrap operands (MAX_VAL+1 becomes 0; 0-1 becomes MAX_VAL); without it, operands SHALL saturate per REQ-013.

Structure
REQ-026 SHALL take from shared package calc_pkg:
- op encoding typedef
- MAX_VAL default
- 7-segment constants for digits 0-9, blank and minus.
REQ-027 SHALL implement digit multiplexing and BCD-to-segment decode in one sub-module, calc_ssg_mux. Its inputs SHALL be four 4-bit digit codes plus the refresh counter; its outputs SHALL be ssgAnode and ssg.

Verification
REQ-028 SHALL pass: reset, then 10 pulses with B[8:5]=4'b1111 -> n1=0, n2=0 (up and down cancel).
REQ-029 SHALL pass: 9 pulses of B[5] with B[0]=1, then press SUB -> n1=9, n2=0, result=9, neg=0.
REQ-030 SHALL pass: n1=9, 3 pulses of B[7] -> n2=3; then DIV -> result=3; then MUL -> result=27, with the display showing "  27".
REQ-031 SHALL pass: n1=0, n2=5, SUB, B[0]=1 -> result=5, neg=1, digit 3 segments = minus.
REQ-032 SHALL pass: n2=0, DIV -> result=0, err=1, display shows "----"; then B[7] pulse -> err=0.
REQ-033 SHALL pass: 100 B[5] pulses -> n1=99 without CALC_WRAP_EN, and n1=0 with it.
